// File: rtl/wb_stage.sv
// MEM/WB pipeline register with RV32 load extraction, writeback source select and
// register-file write port. Optional retired-instruction counter under WB_INSTRET_EN.
module wb_stage #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mem_valid,
    input  logic            stall,
    input  logic            flush,
    input  logic            reg_write,
    input  logic [1:0]      wb_sel,
    input  logic [2:0]      funct3,
    input  logic [RD_W-1:0] rd,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] read_data,
    input  logic [XLEN-1:0] pc_plus4,
    output logic            wb_valid,
    output logic            wb_en,
    output logic [RD_W-1:0] wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            load_misaligned
`ifdef WB_INSTRET_EN
    ,
    output logic [63:0]     instret
`endif
);

    localparam logic [1:0] SEL_LOAD = 2'b01;
    localparam logic [1:0] SEL_PC4  = 2'b10;
    localparam logic [2:0] F3_LB    = 3'b000;
    localparam logic [2:0] F3_LH    = 3'b001;
    localparam logic [2:0] F3_LW    = 3'b010;
    localparam logic [2:0] F3_LBU   = 3'b100;
    localparam logic [2:0] F3_LHU   = 3'b101;

    function automatic logic [XLEN-1:0] load_extract(input logic [2:0]      f3,
                                                     input logic [1:0]      off,
                                                     input logic [XLEN-1:0] word);
        logic        [7:0]  byte_v;
        logic        [15:0] half_v;
        logic signed [7:0]  byte_s;
        logic signed [15:0] half_s;
        case (off)
            2'd0:    byte_v = word[7:0];
            2'd1:    byte_v = word[15:8];
            2'd2:    byte_v = word[23:16];
            default: byte_v = word[31:24];
        endcase
        half_v = off[1] ? word[31:16] : word[15:0];
        byte_s = byte_v;
        half_s = half_v;
        case (f3)
            F3_LB:   load_extract = XLEN'(byte_s);
            F3_LBU:  load_extract = XLEN'(byte_v);
            F3_LH:   load_extract = XLEN'(half_s);
            F3_LHU:  load_extract = XLEN'(half_v);
            default: load_extract = word;
        endcase
    endfunction

    logic            valid_q, valid_d;
    logic            rw_q,    rw_d;
    logic [1:0]      sel_q,   sel_d;
    logic [2:0]      f3_q,    f3_d;
    logic [RD_W-1:0] rd_q,    rd_d;
    logic [XLEN-1:0] alu_q,   alu_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic [XLEN-1:0] pc4_q,   pc4_d;

    // flush beats stall; a stalled slot keeps every field
    always_comb begin
        valid_d = valid_q;
        rw_d    = rw_q;
        sel_d   = sel_q;
        f3_d    = f3_q;
        rd_d    = rd_q;
        alu_d   = alu_q;
        rdata_d = rdata_q;
        pc4_d   = pc4_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (!stall) begin
            valid_d = mem_valid;
            rw_d    = reg_write;
            sel_d   = wb_sel;
            f3_d    = funct3;
            rd_d    = rd;
            alu_d   = alu_result;
            rdata_d = read_data;
            pc4_d   = pc_plus4;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            rw_q    <= 1'b0;
            sel_q   <= '0;
            f3_q    <= '0;
            rd_q    <= '0;
            alu_q   <= '0;
            rdata_q <= '0;
            pc4_q   <= '0;
        end else begin
            valid_q <= valid_d;
            rw_q    <= rw_d;
            sel_q   <= sel_d;
            f3_q    <= f3_d;
            rd_q    <= rd_d;
            alu_q   <= alu_d;
            rdata_q <= rdata_d;
            pc4_q   <= pc4_d;
        end
    end

    logic [1:0] off;
    logic       is_half;

    assign off             = alu_q[1:0];
    assign is_half         = (f3_q == F3_LH) || (f3_q == F3_LHU);
    assign load_misaligned = valid_q && (sel_q == SEL_LOAD) &&
                             ((is_half && off[0]) || ((f3_q == F3_LW) && (off != 2'b00)));

    always_comb begin
        wb_data = '0;
        if (valid_q) begin
            case (sel_q)
                SEL_LOAD: wb_data = load_extract(f3_q, off, rdata_q);
                SEL_PC4:  wb_data = pc4_q;
                default:  wb_data = alu_q;
            endcase
        end
    end

    assign wb_valid = valid_q;
    assign wb_rd    = valid_q ? rd_q : '0;
    // stall is the only input reaching an output: a held slot writes on its first free cycle
    assign wb_en    = valid_q && rw_q && (rd_q != '0) && !load_misaligned && !stall;

`ifdef WB_INSTRET_EN
    logic [63:0] instret_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instret_q <= '0;
        end else if (valid_q && !stall && !load_misaligned) begin
            instret_q <= instret_q + 64'd1;
        end
    end

    assign instret = instret_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios followed by randomized traffic
// compared against a transaction-level reference model.
module tb_wb_stage;

    typedef struct {
        logic        valid;
        logic        rw;
        logic [1:0]  sel;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [31:0] addr;
        logic [31:0] rdata;
        logic [31:0] pc4;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid, stall, flush, reg_write;
    logic [1:0]  wb_sel;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [31:0] alu_result, read_data, pc_plus4;
    logic        wb_valid, wb_en, load_misaligned;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
`ifdef WB_INSTRET_EN
    logic [63:0] instret;
    logic [63:0] saved_cnt;
`endif

    int          passed = 0;
    int          total  = 0;
    txn_t        m;
    logic [63:0] m_cnt;

    always #5 clk = ~clk;

    wb_stage #(.XLEN(32), .RD_W(5)) dut (
        .clk             (clk),
        .rst             (rst),
        .mem_valid       (mem_valid),
        .stall           (stall),
        .flush           (flush),
        .reg_write       (reg_write),
        .wb_sel          (wb_sel),
        .funct3          (funct3),
        .rd              (rd),
        .alu_result      (alu_result),
        .read_data       (read_data),
        .pc_plus4        (pc_plus4),
        .wb_valid        (wb_valid),
        .wb_en           (wb_en),
        .wb_rd           (wb_rd),
        .wb_data         (wb_data),
        .load_misaligned (load_misaligned)
`ifdef WB_INSTRET_EN
        ,
        .instret         (instret)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Reference: a load is misaligned when its address is not a multiple of its access size.
    function automatic bit ref_mis(input txn_t t);
        int unsigned a;
        a = t.addr;
        if (!t.valid || t.sel != 2'd1) return 1'b0;
        if (t.f3 == 3'd1 || t.f3 == 3'd5) return (a % 2) != 0;
        if (t.f3 == 3'd2) return (a % 4) != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input txn_t t);
        int unsigned off, b, h;
        off = t.addr % 4;
        b   = (t.rdata >> (8 * off)) % 256;
        h   = (t.rdata >> (16 * (off / 2))) % 65536;
        case (t.f3)
            3'd0:    return (b >= 128) ? b - 256 : b;
            3'd4:    return b;
            3'd1:    return (h >= 32768) ? h - 65536 : h;
            3'd5:    return h;
            default: return t.rdata;
        endcase
    endfunction

    function automatic logic [31:0] ref_data(input txn_t t);
        if (!t.valid) return 32'd0;
        if (t.sel == 2'd1) return ref_load(t);
        if (t.sel == 2'd2) return t.pc4;
        return t.addr;
    endfunction

    task automatic check_outputs();
        bit en;
        en = m.valid && m.rw && (m.rd != 0) && !ref_mis(m) && !stall;
        check("wb_valid", 64'(wb_valid), 64'(m.valid));
        check("wb_en", 64'(wb_en), 64'(en));
        check("wb_rd", 64'(wb_rd), m.valid ? 64'(m.rd) : 64'd0);
        check("wb_data", 64'(wb_data), 64'(ref_data(m)));
        check("load_misaligned", 64'(load_misaligned), 64'(ref_mis(m)));
`ifdef WB_INSTRET_EN
        check("instret", instret, m_cnt);
`endif
    endtask

    // Called just after an active edge with inputs already set for the coming edge.
    task automatic cycle();
        #1;
        check_outputs();
        @(posedge clk);
        if (m.valid && !stall && !ref_mis(m)) m_cnt = m_cnt + 64'd1;
        if (flush) begin
            m.valid = 1'b0;
        end else if (!stall) begin
            m.valid = mem_valid;
            m.rw    = reg_write;
            m.sel   = wb_sel;
            m.f3    = funct3;
            m.rd    = rd;
            m.addr  = alu_result;
            m.rdata = read_data;
            m.pc4   = pc_plus4;
        end
        #1;
    endtask

    task automatic set_mem(input logic v, input logic rw, input logic [1:0] sel,
                           input logic [2:0] f3, input logic [4:0] d,
                           input logic [31:0] addr, input logic [31:0] rdata,
                           input logic [31:0] pc4);
        mem_valid  = v;
        reg_write  = rw;
        wb_sel     = sel;
        funct3     = f3;
        rd         = d;
        alu_result = addr;
        read_data  = rdata;
        pc_plus4   = pc4;
    endtask

    task automatic idle();
        set_mem(1'b0, 1'b0, 2'd0, 3'd0, 5'd0, 32'd0, 32'd0, 32'd0);
        stall = 1'b0;
        flush = 1'b0;
    endtask

    initial begin
        logic [2:0] f3_pool [8];
        f3_pool = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
        m     = '{default: '0};
        m_cnt = 64'd0;
        rst   = 1'b1;
        idle();
        #1;
        check_outputs();
        #1 rst = 1'b0;

        // LB with sign extension from the top byte
        set_mem(1'b1, 1'b1, 2'd1, 3'd0, 5'd5, 32'h103, 32'h80AB_CD12, 32'h0);
        cycle();
        idle();
        #1;
        check("lb_en", 64'(wb_en), 64'd1);
        check("lb_rd", 64'(wb_rd), 64'd5);
        check("lb_data", 64'(wb_data), 64'hFFFF_FF80);

        // LHU then LH from the upper halfword
        set_mem(1'b1, 1'b1, 2'd1, 3'd5, 5'd6, 32'h102, 32'h9234_5678, 32'h0);
        cycle();
        idle();
        #1;
        check("lhu_data", 64'(wb_data), 64'h0000_9234);
        set_mem(1'b1, 1'b1, 2'd1, 3'd1, 5'd6, 32'h102, 32'h9234_5678, 32'h0);
        cycle();
        idle();
        #1;
        check("lh_data", 64'(wb_data), 64'hFFFF_9234);

        // Misaligned LW never writes and does not retire
        set_mem(1'b1, 1'b1, 2'd1, 3'd2, 5'd8, 32'h101, 32'hDEAD_BEEF, 32'h0);
        cycle();
        idle();
        #1;
        check("lw_mis", 64'(load_misaligned), 64'd1);
        check("lw_mis_en", 64'(wb_en), 64'd0);
`ifdef WB_INSTRET_EN
        saved_cnt = instret;
        cycle();
        check("lw_mis_instret", instret, saved_cnt);
`endif

        // pc_plus4 source, then the same to x0
        set_mem(1'b1, 1'b1, 2'd2, 3'd0, 5'd1, 32'h7777_0000, 32'h1111_1111, 32'h44);
        cycle();
        idle();
        #1;
        check("jal_data", 64'(wb_data), 64'h44);
        check("jal_en", 64'(wb_en), 64'd1);
        set_mem(1'b1, 1'b1, 2'd2, 3'd0, 5'd0, 32'h7777_0000, 32'h1111_1111, 32'h44);
        cycle();
        idle();
        #1;
        check("x0_data", 64'(wb_data), 64'h44);
        check("x0_en", 64'(wb_en), 64'd0);

        // Stall for three cycles, then a single write
        set_mem(1'b1, 1'b1, 2'd0, 3'd0, 5'd7, 32'h1234, 32'h0, 32'h0);
        cycle();
        for (int i = 0; i < 3; i++) begin
            set_mem(1'b1, 1'b1, 2'd0, 3'd0, 5'd9, 32'h5555, 32'h0, 32'h0);
            stall = 1'b1;
            #1;
            check("stall_en", 64'(wb_en), 64'd0);
            check("stall_data", 64'(wb_data), 64'h1234);
            check("stall_rd", 64'(wb_rd), 64'd7);
            cycle();
        end
        idle();
        #1;
        check("unstall_en", 64'(wb_en), 64'd1);
        cycle();
        #1;
        check("after_write_en", 64'(wb_en), 64'd0);

        // Flush while stalled discards the held instruction
        set_mem(1'b1, 1'b1, 2'd0, 3'd0, 5'd7, 32'h1234, 32'h0, 32'h0);
        cycle();
        stall = 1'b1;
        cycle();
        flush = 1'b1;
        cycle();
        idle();
        #1;
        check("flush_valid", 64'(wb_valid), 64'd0);
        check("flush_en", 64'(wb_en), 64'd0);
        cycle();

        // Asynchronous reset in the middle of a cycle
        set_mem(1'b1, 1'b1, 2'd0, 3'd0, 5'd3, 32'hABCD, 32'h0, 32'h0);
        cycle();
        idle();
        #1 rst = 1'b1;
        #1;
        check("rst_valid", 64'(wb_valid), 64'd0);
        check("rst_en", 64'(wb_en), 64'd0);
        check("rst_rd", 64'(wb_rd), 64'd0);
        check("rst_data", 64'(wb_data), 64'd0);
        check("rst_mis", 64'(load_misaligned), 64'd0);
`ifdef WB_INSTRET_EN
        check("rst_instret", instret, 64'd0);
`endif
        m.valid = 1'b0;
        m_cnt   = 64'd0;
        rst     = 1'b0;
        cycle();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            set_mem(($urandom % 4) != 0, ($urandom % 4) != 0, 2'($urandom % 4),
                    f3_pool[$urandom % 8],
                    (($urandom % 6) == 0) ? 5'd0 : 5'($urandom),
                    $urandom, $urandom, $urandom);
            stall = ($urandom % 4) == 0;
            flush = ($urandom % 8) == 0;
            cycle();
        end
        idle();
        cycle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
MEM/WB pipeline register plus writeback logic, directly downstream of the data-memory stage. Captures the memory stage's load data and ALU result each cycle. Performs RV32 sub-word load extraction and sign/zero extension, selects the writeback source, and drives the register-file write port. Its registered outputs double as the WB-stage forwarding source for the hazard unit.

Parameters:
XLEN, 32, datapath width; only 32 is supported.
RD_W, 5, destination register index width.

Ports:
clk  input  1  pipeline clock, rising edge.
rst  input  1  asynchronous, active-high reset.
mem_valid  input  1  the MEM-stage slot holds a real instruction; 0 means bubble.
stall  input  1  freeze: hold the WB register and suppress writeback this cycle.
flush  input  1  squash: load a bubble into the WB register.
reg_write  input  1  the instruction writes rd.
wb_sel  input  2  source: 00 ALU result, 01 load data, 10 pc_plus4, 11 reserved (acts as 00).
funct3  input  3  load width/sign code: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
rd  input  RD_W  destination register.
alu_result  input  XLEN  ALU result, which is also the load address.
read_data  input  XLEN  word returned by the data memory for the current address; 0 when no read.
pc_plus4  input  XLEN  link value for JAL/JALR.
wb_valid  output  1  the WB register holds a real instruction.
wb_en  output  1  register-file write enable.
wb_rd  output  RD_W  register-file write index.
wb_data  output  XLEN  register-file write data.
load_misaligned  output  1  the held load is misaligned.

Behaviour:
- Register update on posedge clk, priority rst > flush > stall > capture:
  - rst (asynchronous): all state cleared. wb_valid=0, wb_en=0, wb_rd=0, wb_data=0, load_misaligned=0.
  - flush=1: valid<=0; other fields are don't-care. flush wins over a simultaneous stall.
  - stall=1, flush=0: all fields hold.
  - otherwise: valid<=mem_valid. Capture reg_write, wb_sel, funct3, rd, alu_result, alu_result[1:0] as byte offset, read_data, pc_plus4.
- Latency: exactly one cycle from MEM inputs to WB outputs. All outputs are combinational from registered state only; no input-to-output combinational path except stall into wb_en.
- Load extraction uses the registered byte offset off:
  - LB/LBU: byte read_data[8*off+7:8*off], sign- or zero-extended to 32 bits.
  - LH/LHU: halfword read_data[16*off[1]+15:16*off[1]], sign- or zero-extended to 32 bits.
  - LW and codes 011/110/111: the full word.
- Misalignment:
  - load_misaligned = valid & wb_sel==01 & ((LH|LHU) & off[0] | LW & off!=0).
  - Misaligned loads never write.
- wb_data = 0 when valid=0. Otherwise it is the selected source (extracted load data for wb_sel=01).
- wb_rd = registered rd (0 when valid=0).
- wb_en = valid & reg_write & (rd!=0) & !load_misaligned & !stall. Writes to x0 are always suppressed.
- A held instruction writes exactly once, on the first non-stall cycle.
- A flush issued while stalled discards the held instruction; it never writes.
- Reset mid-operation drops the held instruction immediately. No write is issued in the reset cycle.

Optional Feature:
Macro WB_INSTRET_EN.
- Defined: adds output port instret, 64 bits, reset to 0 asynchronously by rst. It increments by 1 on posedge clk when valid & !stall & !load_misaligned, counting each retired instruction exactly once including non-writing ones. It wraps from 2^64-1 to 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- LB sign: mem_valid=1, reg_write=1, wb_sel=01, funct3=000, rd=5, alu_result=0x103, read_data=0x80AB_CD12 -> next cycle wb_en=1, wb_rd=5, wb_data=0xFFFF_FF80.
- LHU/LH: alu_result=0x102, read_data=0x9234_5678. funct3=101 -> wb_data=0x0000_9234; funct3=001 -> wb_data=0xFFFF_9234.
- Misaligned: LW at alu_result=0x101 -> load_misaligned=1, wb_en=0. With WB_INSTRET_EN defined, instret is unchanged.
- Source select and x0: wb_sel=10, pc_plus4=0x0000_0044, rd=1 -> wb_data=0x44, wb_en=1. Same instruction with rd=0 -> wb_en=0, wb_data=0x44.
- Stall/flush:
  - ALU op with alu_result=0x1234, rd=7, then stall=1 for 3 cycles -> wb_en=0 and outputs held for 3 cycles, then wb_en=1 for exactly one cycle.
  - Repeat with flush=1 during the stall -> wb_valid=0 and no write ever occurs.
- Reset: assert rst asynchronously mid-cycle while wb_valid=1 -> all outputs 0 before the next clock edge, and instret=0.
